subneg_mem_responder: RTL

SUBNEG_MEM_RESPONDER -- requirements
Module: subneg_mem_responder

---
 rtl/subneg_mem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/subneg_mem_responder.sv
// subneg_mem_responder
//   Byte-wide memory target for a strobe-driven (latch / OE / WE) initiator bus,
//   with a host preload port and an edge-captured output latch.
//
//   Ports:
//     clk, reset          single clock; synchronous active-high reset
//     bus_in[7:0]         initiator data bus (address or write data)
//     latch_clk           address latch strobe (rising edge captures address)
//     mem_oe_n, mem_we_n  read / write strobes, active-low
//     out_latch_clk       output latch strobe (rising edge captures bus_in)
//     host_sel            host owns the memory when high
//     load_we/addr/data   host preload write port
//     bus_out[7:0]        combinational read data, mem[addr_reg]
//     bus_drive           combinational bus-drive enable
//     out_port[7:0]       output latch, out_strobe one-cycle capture pulse
//     bus_conflict        sticky OE+WE overlap flag
//     wr_count[15:0]      committed bus-write counter
//
//   Optional feature: define SUBNEG_RESP_WRCNT_EN to build the saturating
//   write counter; otherwise wr_count is tied to zero.
module subneg_mem_responder #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        bus_in,
  input  logic              latch_clk,
  input  logic              mem_oe_n,
  input  logic              mem_we_n,
  input  logic              out_latch_clk,
  input  logic              host_sel,
  input  logic              load_we,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [7:0]        bus_out,
  output logic              bus_drive,
  output logic [7:0]        out_port,
  output logic              out_strobe,
  output logic              bus_conflict,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } phase_e;

  phase_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              latch_prev_q, latch_prev_d;
  logic              we_n_prev_q, we_n_prev_d;
  logic              olatch_prev_q, olatch_prev_d;
  logic [DW-1:0]     out_port_q, out_port_d;
  logic              out_strobe_q, out_strobe_d;
  logic              conflict_q, conflict_d;

  logic [DW-1:0]     mem [DEPTH];

  logic              bus_en;
  logic              latch_rise;
  logic              we_fall;
  logic              olatch_rise;
  logic              mem_wr_en;
  logic [MEM_AW-1:0] mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;

  // Edge detection; bus strobes are ignored while the host owns the memory
  always_comb begin
    bus_en      = !host_sel;
    latch_rise  = bus_en && latch_clk && !latch_prev_q;
    we_fall     = bus_en && !mem_we_n && we_n_prev_q;
    olatch_rise = bus_en && out_latch_clk && !olatch_prev_q;
  end

  // Next-state, address, output latch and flag logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    out_port_d    = out_port_q;
    out_strobe_d  = 1'b0;
    conflict_d    = conflict_q;
    // History keeps tracking during host ownership so no false edge appears later
    latch_prev_d  = latch_clk;
    we_n_prev_d   = mem_we_n;
    olatch_prev_d = out_latch_clk;

    if (bus_en) begin
      if (latch_rise) begin
        state_d = ADDR;
      end else if (!mem_oe_n && (state_q == ADDR || state_q == READ)) begin
        state_d = READ;
      end else if (we_fall) begin
        state_d = WRITE;
      end else if (!latch_clk && mem_oe_n && mem_we_n) begin
        state_d = IDLE;
      end
    end

    if (latch_rise) begin
      addr_d = bus_in[MEM_AW-1:0];
    end

    if (olatch_rise) begin
      out_port_d   = bus_in;
      out_strobe_d = 1'b1;
    end

    if (bus_en && !mem_oe_n && !mem_we_n) begin
      conflict_d = 1'b1;
    end
  end

  // Memory write port select: host preload or a single bus write per WE pulse
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = addr_q;
    mem_wr_data = bus_in;
    if (!reset) begin
      if (host_sel) begin
        mem_wr_en   = load_we;
        mem_wr_addr = load_addr;
        mem_wr_data = load_data;
      end else if (we_fall) begin
        // Uses the pre-update addr_q, so a same-cycle latch lands on the old address
        mem_wr_en   = 1'b1;
        mem_wr_addr = addr_q;
        mem_wr_data = bus_in;
      end
    end
  end

  // Control register bank
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      latch_prev_q  <= 1'b0;
      we_n_prev_q   <= 1'b1;
      olatch_prev_q <= 1'b0;
      out_port_q    <= '0;
      out_strobe_q  <= 1'b0;
      conflict_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      latch_prev_q  <= latch_prev_d;
      we_n_prev_q   <= we_n_prev_d;
      olatch_prev_q <= olatch_prev_d;
      out_port_q    <= out_port_d;
      out_strobe_q  <= out_strobe_d;
      conflict_q    <= conflict_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // Zero-latency read from the latched address
  assign bus_out      = mem[addr_q];
  assign bus_drive    = !mem_oe_n && mem_we_n && !host_sel;
  assign out_port     = out_port_q;
  assign out_strobe   = out_strobe_q;
  assign bus_conflict = conflict_q;

`ifdef SUBNEG_RESP_WRCNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  // Saturating count of committed bus writes; host preloads excluded
  always_comb begin
    wr_count_d = wr_count_q;
    if (!host_sel && we_fall && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`else
  assign wr_count = '0;
`endif

endmodule
